// File: rtl/nios_buttons_debounced.sv
// Avalon-MM button PIO slave: synchronises and debounces WIDTH inputs, detects selectable
// edges into a write-1-to-clear capture register, and raises a level- or edge-sourced irq.
module nios_buttons_debounced #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] IDLE_VALUE      = {WIDTH{1'b1}},
  parameter int               IRQ_MODE        = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [CNT_W-1:0] cnt [WIDTH];

  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] edge_capture;

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] capture_clr;
  logic [WIDTH-1:0] irq_src;
  logic [31:0]      read_mux;

  assign wr_en       = chipselect && !write_n;
  assign wdata       = writedata[WIDTH-1:0];
  assign rise        = stable & ~stable_d;
  assign fall        = ~stable & stable_d;
  assign edge_hit    = (rise & rise_en) | (fall & fall_en);
  assign capture_clr = (wr_en && (address == 3'd3)) ? wdata : '0;
  assign irq_src     = (IRQ_MODE == 0) ? stable : edge_capture;

  // stable_d resets to the idle value too, so leaving reset never looks like an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= IDLE_VALUE;
      sync2    <= IDLE_VALUE;
      stable   <= IDLE_VALUE;
      stable_d <= IDLE_VALUE;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1    <= in_port;
      sync2    <= sync1;
      stable_d <= stable;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A new edge outranks a simultaneous write-1-to-clear of the same bit
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask     <= '0;
      rise_en      <= '0;
      fall_en      <= '1;
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~capture_clr) | edge_hit;
      if (wr_en) begin
        case (address)
          3'd2:    irq_mask <= wdata;
          3'd4:    rise_en  <= wdata;
          3'd5:    fall_en  <= wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    read_mux = '0;
    case (address)
      3'd0:    read_mux = 32'(stable);
      3'd1:    read_mux = 32'(sync2);
      3'd2:    read_mux = 32'(irq_mask);
      3'd3:    read_mux = 32'(edge_capture);
      3'd4:    read_mux = 32'(rise_en);
      3'd5:    read_mux = 32'(fall_en);
      default: read_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= read_mux;
      irq      <= |(irq_src & irq_mask);
    end
  end

endmodule

// File: tb/tb_nios_buttons_debounced.sv
// Directed bench for nios_buttons_debounced: an edge-irq instance (idle high) and a
// level-irq instance (idle low) share clock, reset and the address/data bus.
module tb_nios_buttons_debounced;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        cs1;
  logic        cs2;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port1;
  logic [3:0]  in_port2;
  logic [31:0] readdata1;
  logic [31:0] readdata2;
  logic        irq1;
  logic        irq2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nios_buttons_debounced #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4), .IDLE_VALUE(4'hF), .IRQ_MODE(1)
  ) u_dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs1),
    .write_n(write_n), .writedata(writedata), .in_port(in_port1),
    .readdata(readdata1), .irq(irq1)
  );

  nios_buttons_debounced #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4), .IDLE_VALUE(4'h0), .IRQ_MODE(0)
  ) u_dut_lvl (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs2),
    .write_n(write_n), .writedata(writedata), .in_port(in_port2),
    .readdata(readdata2), .irq(irq2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic applyStimulus(input int dev, input logic [3:0] value, input int cycles);
    if (dev == 1) in_port1 = value;
    else          in_port2 = value;
    waitCycles(cycles);
  endtask

  task automatic readReg(input int dev, input logic [2:0] addr, output logic [31:0] data);
    address = addr;
    @(negedge clk);
    data = (dev == 1) ? readdata1 : readdata2;
  endtask

  task automatic writeReg(input int dev, input logic [2:0] addr, input logic [31:0] data);
    address   = addr;
    writedata = data;
    cs1       = (dev == 1);
    cs2       = (dev == 2);
    write_n   = 1'b0;
    @(negedge clk);
    write_n   = 1'b1;
    cs1       = 1'b0;
    cs2       = 1'b0;
  endtask

  logic [31:0] rd;
  logic [31:0] rd_trace [1:8];
  logic        irq_trace [1:8];
  int          e_count;

  initial begin
    reset     = 1'b1;
    address   = 3'd0;
    cs1       = 1'b0;
    cs2       = 1'b0;
    write_n   = 1'b1;
    writedata = '0;
    in_port1  = 4'hF;
    in_port2  = 4'h0;
    waitCycles(4);
    checkOutput("reset_readdata", readdata1, 32'h0);
    checkOutput("reset_irq", {31'b0, irq1}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_irq", {31'b0, irq1}, 32'h0);
    readReg(1, 3'd0, rd); checkOutput("reset_stable", rd, 32'hF);
    readReg(1, 3'd3, rd); checkOutput("reset_capture", rd, 32'h0);
    readReg(1, 3'd4, rd); checkOutput("reset_rise_en", rd, 32'h0);
    readReg(1, 3'd5, rd); checkOutput("reset_fall_en", rd, 32'hF);
    readReg(1, 3'd2, rd); checkOutput("reset_mask", rd, 32'h0);
    waitCycles(20);
    readReg(1, 3'd3, rd); checkOutput("idle_no_capture", rd, 32'h0);

    // 3-cycle glitch on bit 0: visible on sync2 for exactly 3 reads, never reaches stable
    address = 3'd1;
    @(negedge clk);
    in_port1 = 4'hE;
    e_count  = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (readdata1[3:0] == 4'hE) e_count++;
      if (i == 3) in_port1 = 4'hF;
    end
    checkOutput("bounce_sync_cycles", 32'(e_count), 32'd3);
    waitCycles(6);
    readReg(1, 3'd0, rd); checkOutput("bounce_stable", rd, 32'hF);
    readReg(1, 3'd3, rd); checkOutput("bounce_capture", rd, 32'h0);

    // Press bit 0 with mask 1: stable at edge k+5, capture at k+6, irq at k+7
    writeReg(1, 3'd2, 32'h1);
    readReg(1, 3'd2, rd); checkOutput("mask_readback", rd, 32'h1);
    address  = 3'd0;
    @(negedge clk);
    in_port1 = 4'hE;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      rd_trace[i]  = readdata1;
      irq_trace[i] = irq1;
    end
    checkOutput("press_stable_before", rd_trace[6], 32'hF);
    checkOutput("press_stable_after", rd_trace[7], 32'hE);
    checkOutput("press_irq_before", {31'b0, irq_trace[7]}, 32'h0);
    checkOutput("press_irq_after", {31'b0, irq_trace[8]}, 32'h1);
    readReg(1, 3'd3, rd); checkOutput("press_capture", rd, 32'h1);
    writeReg(1, 3'd3, 32'h1);
    checkOutput("w1c_irq_hold", {31'b0, irq1}, 32'h1);
    @(negedge clk);
    checkOutput("w1c_irq_fall", {31'b0, irq1}, 32'h0);
    readReg(1, 3'd3, rd); checkOutput("w1c_capture", rd, 32'h0);

    // Both-edge mode on bit 1, then both enables off
    writeReg(1, 3'd4, 32'h2);
    applyStimulus(1, 4'hC, 10);
    readReg(1, 3'd3, rd); checkOutput("any_press_capture", rd, 32'h2);
    writeReg(1, 3'd3, 32'h2);
    readReg(1, 3'd3, rd); checkOutput("any_cleared", rd, 32'h0);
    applyStimulus(1, 4'hE, 10);
    readReg(1, 3'd3, rd); checkOutput("any_release_capture", rd, 32'h2);
    writeReg(1, 3'd3, 32'h2);
    writeReg(1, 3'd4, 32'h0);
    writeReg(1, 3'd5, 32'h0);
    readReg(1, 3'd5, rd); checkOutput("fall_en_readback", rd, 32'h0);
    applyStimulus(1, 4'hC, 10);
    applyStimulus(1, 4'hE, 10);
    readReg(1, 3'd3, rd); checkOutput("disabled_no_capture", rd, 32'h0);
    readReg(1, 3'd7, rd); checkOutput("addr7_zero", rd, 32'h0);

    // W1C on bit 2 lands on the same edge that captures its fall: set wins
    writeReg(1, 3'd5, 32'hF);
    applyStimulus(1, 4'hA, 6);
    writeReg(1, 3'd3, 32'h4);
    readReg(1, 3'd3, rd); checkOutput("collision_set_wins", rd, 32'h4);
    writeReg(1, 3'd3, 32'h4);
    readReg(1, 3'd3, rd); checkOutput("collision_cleared", rd, 32'h0);

    // Level-irq instance, idle low, mask bit 3
    writeReg(2, 3'd2, 32'h8);
    waitCycles(3);
    checkOutput("lvl_irq_idle", {31'b0, irq2}, 32'h0);
    address = 3'd0;
    @(negedge clk);
    in_port2 = 4'h8;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      rd_trace[i]  = readdata2;
      irq_trace[i] = irq2;
    end
    checkOutput("lvl_irq_before", {31'b0, irq_trace[6]}, 32'h0);
    checkOutput("lvl_irq_after", {31'b0, irq_trace[7]}, 32'h1);
    checkOutput("lvl_stable", rd_trace[7], 32'h8);
    writeReg(2, 3'd2, 32'h0);
    checkOutput("lvl_irq_hold", {31'b0, irq2}, 32'h1);
    @(negedge clk);
    checkOutput("lvl_irq_masked", {31'b0, irq2}, 32'h0);
    checkOutput("edge_dut_irq_quiet", {31'b0, irq1}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios_buttons_debounced.md
Name: nios_buttons_debounced

Overview:
- Parametrised successor to the Avalon-MM button PIO slave on the Nios system bus.
- Synchronises and debounces WIDTH mechanical inputs, with a per-bit counter filter.
- Edge detection is software-selectable per bit: rising, falling or both.
- Edge capture register clears per bit (write-1-to-clear).
- IRQ is generated from either the debounced level or the captured edges, chosen by parameter.

Parameters:
- WIDTH, 4: number of input bits; 1..32.
- DEBOUNCE_CYCLES, 50000: consecutive cycles a synchronised input must differ from the stable value before the stable value changes; >= 1.
- IDLE_VALUE, {WIDTH{1'b1}}: reset value of synchroniser and stable registers. Buttons are active-low, idle high.
- IRQ_MODE, 1: 0 = level (irq from debounced data & mask); 1 = edge (irq from edge_capture & mask).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  3  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits [WIDTH-1:0] used.
- in_port  in  WIDTH  raw asynchronous button inputs.
- readdata  out  32  registered read data; upper bits zero.
- irq  out  1  interrupt request, active high.

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high.
- On reset:
  - readdata = 0.
  - irq_mask = 0.
  - edge_capture = 0.
  - rise_en = 0.
  - fall_en = all ones.
  - sync1, sync2 and stable = IDLE_VALUE.
  - debounce counters = 0.
  - Consequence: irq = 0 in the cycle after reset.
- Synchroniser: two flops per bit, sync1 <= in_port, then sync2 <= sync1.
- Debounce, per bit, counter width clog2(DEBOUNCE_CYCLES+1):
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at sync2 never reaches stable.
- Latency: in_port steady from before edge k gives stable updated at edge k+1+DEBOUNCE_CYCLES.
- Edge detect: stable_d <= stable every cycle.
  - rise = stable & ~stable_d.
  - fall = ~stable & stable_d.
  - edge = (rise & rise_en) | (fall & fall_en).
- Edge capture, per bit:
  - Set on edge.
  - Cleared by a write to address 3 where writedata bit = 1.
  - Simultaneous set and clear on the same bit: set wins.
  - Bits written 0 are unchanged.
- Register map:
  - Writes occur when chipselect && !write_n.
  - Reads: readdata <= zero-extended mux every cycle; valid one cycle after the address is presented (read latency 1).
  - 0: debounced data (stable), RO.
  - 1: raw synchronised data (sync2), RO.
  - 2: irq_mask, RW.
  - 3: edge_capture, R / W1C.
  - 4: rise_en, RW.
  - 5: fall_en, RW.
  - 6 and 7: read 0; writes ignored.
- IRQ:
  - Registered: irq <= |(src & irq_mask), so it updates one cycle after src or mask changes.
  - src = stable when IRQ_MODE=0; src = edge_capture when IRQ_MODE=1.
- Mode register writes (addresses 4/5) take effect for edges detected on the following cycle. Already-captured bits are unaffected.
- Reset mid-debounce discards partial counts. No edge is generated by reset itself.

Test Plan (sim with WIDTH=4, DEBOUNCE_CYCLES=4, IRQ_MODE=1 unless stated):
- Reset release with in_port=4'hF → read addr 0 = 0xF, addr 3 = 0, addr 5 = 0xF, irq = 0. No edge captured for 20 cycles.
- Bounce rejection: in_port[0] low for 3 cycles then high → addr 0 stays 0xF, addr 1 showed 0xE during the pulse, addr 3 = 0.
- Press filtering: in_port=4'hE held, mask=0x1 → stable changes at edge k+5 and addr 3 = 0x1. irq rises 2 cycles after stable changes. Write 0x1 to addr 3 → irq falls next cycle.
- Any-edge mode: write rise_en=0x2, press then release bit 1 with capture cleared between → capture bit 1 set on both press and release. With rise_en=0 and fall_en=0, nothing is captured.
- Clear/set collision: W1C of bit 2 issued in the same cycle as a new fall on bit 2 → addr 3 bit 2 reads 1. Write 0x4 to addr 3 again → reads 0.
- IRQ_MODE=0, mask=0x8: in_port[3]=0 → irq stays 0. With IDLE_VALUE=0 and in_port[3]=1 held → irq = 1 one cycle after stable[3] = 1. Clearing mask → irq = 0 next cycle.
